// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative multiply and restoring divide.
// Define ALU_MC_SIGNED_MULDIV_EN to add signed MULS (op 12) and DIVS (op 13).
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int DW   = 2 * WIDTH;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
`ifdef ALU_MC_SIGNED_MULDIV_EN
  localparam logic [3:0] OP_MULS = 4'd12;
  localparam logic [3:0] OP_DIVS = 4'd13;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, mcand_r;
  logic             is_mul_r, neg_q_r, neg_r_r, dbz_r;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] result_r, result_hi_r;
  logic             zero_r, div_by_zero_r, illegal_r;

  logic [SH_W-1:0]  shamt_s;
  logic [WIDTH-1:0] alu_s, a_mag_s, b_mag_s;
  logic             illegal_s, muldiv_s, is_mul_s, signed_s, a_neg_s, b_neg_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [DW-1:0]    prod_s, fin_prod_s;
  logic [WIDTH-1:0] fin_q_s, fin_r_s;

  assign shamt_s = b[SH_W-1:0];

  // Op decode and single-cycle result
  always_comb begin
    alu_s     = '0;
    illegal_s = 1'b0;
    muldiv_s  = 1'b0;
    is_mul_s  = 1'b0;
    signed_s  = 1'b0;
    case (op)
      OP_AND:  alu_s = a & b;
      OP_OR:   alu_s = a | b;
      OP_ADD:  alu_s = a + b;
      OP_SUB:  alu_s = a - b;
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  alu_s = a ^ b;
      OP_NOR:  alu_s = ~(a | b);
      OP_SLL:  alu_s = a << shamt_s;
      OP_SRL:  alu_s = a >> shamt_s;
      OP_SRA:  alu_s = WIDTH'($signed(a) >>> shamt_s);
      OP_MULU: begin muldiv_s = 1'b1; is_mul_s = 1'b1; end
      OP_DIVU: muldiv_s = 1'b1;
`ifdef ALU_MC_SIGNED_MULDIV_EN
      OP_MULS: begin muldiv_s = 1'b1; is_mul_s = 1'b1; signed_s = 1'b1; end
      OP_DIVS: begin muldiv_s = 1'b1; signed_s = 1'b1; end
`endif
      default: illegal_s = 1'b1;
    endcase
  end

  // Signed ops iterate on magnitudes and fix the sign at the end
  always_comb begin
    a_neg_s = signed_s & a[WIDTH-1];
    b_neg_s = signed_s & b[WIDTH-1];
    a_mag_s = a_neg_s ? (~a + WIDTH'(1)) : a;
    b_mag_s = b_neg_s ? (~b + WIDTH'(1)) : b;
  end

  // One shift-add / restoring-divide step, plus final sign fix-up
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + {1'b0, mcand_r};
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mcand_r};
    prod_s      = {hi_r, lo_r};
    fin_prod_s  = neg_q_r ? (~prod_s + DW'(1)) : prod_s;
    // A zero divisor keeps the all-ones quotient regardless of sign
    fin_q_s     = (neg_q_r && !dbz_r) ? (~lo_r + WIDTH'(1)) : lo_r;
    fin_r_s     = neg_r_r ? (~hi_r + WIDTH'(1)) : hi_r;
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      hi_r          <= '0;
      lo_r          <= '0;
      mcand_r       <= '0;
      is_mul_r      <= 1'b0;
      neg_q_r       <= 1'b0;
      neg_r_r       <= 1'b0;
      dbz_r         <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      result_r      <= '0;
      result_hi_r   <= '0;
      zero_r        <= 1'b0;
      div_by_zero_r <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            in_ready_r    <= 1'b0;
            div_by_zero_r <= 1'b0;
            if (muldiv_s) begin
              hi_r      <= '0;
              lo_r      <= is_mul_s ? b_mag_s : a_mag_s;
              mcand_r   <= is_mul_s ? a_mag_s : b_mag_s;
              cnt_r     <= CNT_W'(WIDTH);
              is_mul_r  <= is_mul_s;
              neg_q_r   <= a_neg_s ^ b_neg_s;
              neg_r_r   <= a_neg_s;
              dbz_r     <= !is_mul_s && (b == '0);
              illegal_r <= 1'b0;
              state_r   <= BUSY;
            end else begin
              result_r    <= alu_s;
              result_hi_r <= '0;
              zero_r      <= (alu_s == '0);
              illegal_r   <= illegal_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (is_mul_r) begin
              if (lo_r[0]) begin
                {hi_r, lo_r} <= {mul_sum_s, lo_r[WIDTH-1:1]};
              end else begin
                {hi_r, lo_r} <= {1'b0, hi_r, lo_r[WIDTH-1:1]};
              end
            end else begin
              if (!div_diff_s[WIDTH]) begin
                hi_r <= div_diff_s[WIDTH-1:0];
              end else begin
                hi_r <= div_shift_s[WIDTH-1:0];
              end
              lo_r <= {lo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
            end
          end else begin
            if (is_mul_r) begin
              {result_hi_r, result_r} <= fin_prod_s;
              zero_r                  <= (fin_prod_s[WIDTH-1:0] == '0);
            end else begin
              result_r      <= fin_q_s;
              result_hi_r   <= fin_r_s;
              zero_r        <= (fin_q_s == '0);
              div_by_zero_r <= dbz_r;
            end
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign result      = result_r;
  assign result_hi   = result_hi_r;
  assign zero        = zero_r;
  assign div_by_zero = div_by_zero_r;
  assign illegal_op  = illegal_r;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); signed vectors when ALU_MC_SIGNED_MULDIV_EN is defined.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result, result_hi;
  logic        zero, div_by_zero, illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // cyc = clock edges after the accept edge until out_valid is seen (0 for single-cycle ops)
  task automatic wait_done(output int cyc, output bit rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e_lo, input logic [31:0] e_hi, input int e_lat,
                     input logic e_dbz, input logic e_ill);
    int  cyc;
    bit  rdy_seen;
    send(o, x, y);
    wait_done(cyc, rdy_seen);
    check({tag, "_lat"}, 64'(cyc), 64'(e_lat));
    check({tag, "_res"}, 64'(result), 64'(e_lo));
    check({tag, "_hi"}, 64'(result_hi), 64'(e_hi));
    check({tag, "_zero"}, 64'(zero), 64'(e_lo == 32'd0));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
    check({tag, "_ill"}, 64'(illegal_op), 64'(e_ill));
    if (e_lat > 0) check({tag, "_busy_rdy"}, 64'(rdy_seen), 64'd0);
    release_result(tag);
  endtask

  initial begin
    #12;
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_flags", 64'({zero, div_by_zero, illegal_op}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_rdy", 64'(in_ready), 64'd1);

    run("add_a", 4'd2, 32'd2, 32'd3, 32'd5, 32'd0, 0, 1'b0, 1'b0);

    // Reset in the middle of a multiply
    send(4'd10, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_ov", 64'(out_valid), 64'd0);
    check("mrst_res", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mrst_rdy", 64'(in_ready), 64'd1);
    run("add_b", 4'd2, 32'd2, 32'd3, 32'd5, 32'd0, 0, 1'b0, 1'b0);

    run("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 1'b0, 1'b0);
    run("sub_wrap", 4'd3, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, 1'b0);
    run("slt_t", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 0, 1'b0, 1'b0);
    run("slt_f", 4'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 1'b0, 1'b0);
    run("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 0, 1'b0, 1'b0);
    run("or", 4'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 32'd0, 0, 1'b0, 1'b0);
    run("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 32'd0, 0, 1'b0, 1'b0);
    run("nor", 4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 32'd0, 0, 1'b0, 1'b0);
    run("sll31", 4'd7, 32'd1, 32'd31, 32'h8000_0000, 32'd0, 0, 1'b0, 1'b0);
    run("sll0", 4'd7, 32'h1234_5678, 32'h20, 32'h1234_5678, 32'd0, 0, 1'b0, 1'b0);
    run("srl", 4'd8, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd0, 0, 1'b0, 1'b0);

    run("mulu", 4'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 33, 1'b0, 1'b0);
    run("mulu_max", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, 1'b0, 1'b0);
    run("divu", 4'd11, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 1'b0);
    run("divu_z", 4'd11, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 33, 1'b1, 1'b0);
    run("dbz_clr", 4'd2, 32'd1, 32'd1, 32'd2, 32'd0, 0, 1'b0, 1'b0);
    run("ill14", 4'd14, 32'd5, 32'd6, 32'd0, 32'd0, 0, 1'b0, 1'b1);
    run("ill_clr", 4'd1, 32'd5, 32'd2, 32'd7, 32'd0, 0, 1'b0, 1'b0);

    // Backpressure: held result, extra in_valid pulses ignored
    begin
      int  cyc;
      bit  rdy_seen;
      send(4'd9, 32'h8000_0000, 32'd4);
      wait_done(cyc, rdy_seen);
      check("sra_lat", 64'(cyc), 64'd0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        check("bp_res", 64'(result), 64'hF800_0000);
        check("bp_rdy", 64'(in_ready), 64'd0);
        check("bp_ov", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result("bp");
    end

`ifdef ALU_MC_SIGNED_MULDIV_EN
    run("divs", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
    run("muls", 4'd12, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
    run("divs_min", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0, 1'b0);
    run("divs_z", 4'd13, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 33, 1'b1, 1'b0);
`else
    run("ill12", 4'd12, 32'd3, 32'd5, 32'd0, 32'd0, 0, 1'b0, 1'b1);
    run("ill13", 4'd13, 32'd7, 32'd2, 32'd0, 32'd0, 0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
